// File: rtl/kronos_imem_port.sv
// Responder end of the Kronos instruction-fetch req/gnt interface, serving fetches
// from a single-port synchronous SRAM with optional wait states and arbiter stalls.
module kronos_imem_port #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic [31:0]   instr_addr,
    input  logic          instr_req,
    output logic [31:0]   instr_data,
    output logic          instr_gnt,
    output logic          sram_en,
    output logic [AW-1:0] sram_addr,
    input  logic [31:0]   sram_rdata,
    input  logic          arb_busy
);

    typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

    localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);
    localparam bit         NoWait  = (WAIT_STATES == 0);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;

    logic [AW-1:0] word_idx;
    logic          addr_match;
    logic          data_ready;
    logic          gnt_now;
    logic          issue;

    // Byte-offset bits and index bits above the SRAM depth are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr[31:AW+2], instr_addr[1:0]};

    assign word_idx   = instr_addr[AW+1:2];
    assign addr_match = (word_idx == addr_q);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (issue) begin
            addr_d = word_idx;
        end
        case (state_q)
            StIdle: begin
                state_d = issue ? StRead : StIdle;
            end
            StRead: begin
                if (issue) begin
                    state_d = StRead;
                end else if (instr_req && addr_match && !NoWait) begin
                    state_d = StHold;
                    data_d  = sram_rdata;
                    cnt_d   = WaitCnt;
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (issue) begin
                    state_d = StRead;
                end else if (instr_req && addr_match && !data_ready) begin
                    state_d = StHold;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // data_ready marks the cycle a word can be granted; if the initiator has already
    // moved to its next address in that cycle, the new address is issued instead.
    always_comb begin
        data_ready = 1'b0;
        case (state_q)
            StRead:  data_ready = NoWait;
            StHold:  data_ready = (cnt_q == 4'd1);
            default: data_ready = 1'b0;
        endcase
        gnt_now = data_ready & instr_req & addr_match;
        issue   = rstz & instr_req & ~arb_busy &
                  ((state_q == StIdle) | data_ready | ((state_q == StRead) & ~addr_match));

        instr_gnt  = gnt_now;
        instr_data = '0;
        if (gnt_now) begin
            instr_data = (state_q == StRead) ? sram_rdata : data_q;
        end
        sram_en   = issue;
        sram_addr = word_idx;
    end

endmodule

// File: tb/tb_kronos_imem_port.sv
// Bench for kronos_imem_port: three instances (WAIT_STATES 0, 2, 3) share stimulus,
// each backed by its own 1-cycle SRAM model over a common random memory image.
module tb_kronos_imem_port;

    logic        clk = 1'b0;
    logic        rstz;
    logic        req;
    logic        busy;
    logic [31:0] addr;

    logic        gnt[3];
    logic        en[3];
    logic [31:0] data[3];
    logic [7:0]  saddr[3];

    logic [31:0] mem[256];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          sel;
        logic [31:0] addr;
        int          idx;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic [31:0] rd;

        always_ff @(posedge clk) begin
            if (en[k]) rd <= mem[saddr[k]];
        end

        kronos_imem_port #(
            .DEPTH      (256),
            .WAIT_STATES(k == 0 ? 0 : (k == 1 ? 2 : 3))
        ) u_dut (
            .clk       (clk),
            .rstz      (rstz),
            .instr_addr(addr),
            .instr_req (req),
            .instr_data(data[k]),
            .instr_gnt (gnt[k]),
            .sram_en   (en[k]),
            .sram_addr (saddr[k]),
            .sram_rdata(rd),
            .arb_busy  (busy)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        logic [7:0] i;
        i = a[9:2];
        return mem[i];
    endfunction

    // Isolated read from IDLE: issue in cycle 0, grant exactly at cycle lat.
    task automatic single_read(input int sel, input logic [31:0] a, input int idx, input int lat);
        tick();
        req  = 1'b1;
        addr = a;
        busy = 1'b0;
        #1;
        check("issue_en", 32'(en[sel]), 32'd1);
        check("issue_saddr", 32'(saddr[sel]), 32'(idx));
        for (int c = 1; c <= lat; c++) begin
            tick();
            #1;
            if (c < lat) begin
                check("wait_quiet", {30'b0, gnt[sel], en[sel]}, 32'd0);
            end else begin
                check("gnt", 32'(gnt[sel]), 32'd1);
                check("gnt_data", data[sel], mem[idx]);
            end
        end
        req = 1'b0;
        #1;
        check("gnt_no_req", {30'b0, gnt[sel], en[sel]}, 32'd0);
        check("data_zero", data[sel], 32'd0);
    endtask

    // Streaming fetch: the initiator presents base+4*i and moves on in each gnt cycle.
    task automatic stream(input int sel, input logic [31:0] base, input int n,
                          input bit rnd_busy, input int spacing, input int first_lat);
        logic [31:0] q[$];
        logic [31:0] exp;
        int          got       = 0;
        int          last      = -1;
        int          busy_left = 0;
        for (int cyc = 0; cyc < 4000 && got < n; cyc++) begin
            tick();
            if (cyc == 0) begin
                req  = 1'b1;
                addr = base;
                q.push_back(mem_at(base));
            end
            if (rnd_busy) begin
                if (busy_left > 0) begin
                    busy = 1'b1;
                    busy_left--;
                end else if ($urandom_range(0, 1) == 1) begin
                    busy      = 1'b1;
                    busy_left = int'($urandom_range(1, 4)) - 1;
                end else begin
                    busy = 1'b0;
                end
            end else begin
                busy = 1'b0;
            end
            #1;
            if (gnt[sel]) begin
                if (q.size() == 0) begin
                    check("stream_extra_gnt", 32'(q.size()), 32'd1);
                end else begin
                    exp = q.pop_front();
                    check("stream_data", data[sel], exp);
                end
                if (first_lat >= 0 && got == 0) check("stream_first_lat", 32'(cyc), 32'(first_lat));
                if (spacing > 0 && last >= 0) check("stream_spacing", 32'(cyc - last), 32'(spacing));
                last = cyc;
                got++;
                if (got < n) begin
                    addr = base + 32'(4 * got);
                    q.push_back(mem_at(addr));
                end else begin
                    req = 1'b0;
                end
            end
            #1;
            check("busy_blocks_en", 32'(en[sel] & busy), 32'd0);
        end
        req  = 1'b0;
        busy = 1'b0;
        check("stream_count", 32'(got), 32'(n));
        check("stream_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        vecs[0] = '{0, 32'h0000_0000,   0, 1};
        vecs[1] = '{0, 32'h0000_03FC, 255, 1};
        vecs[2] = '{0, 32'h0000_0400,   0, 1};
        vecs[3] = '{0, 32'h0000_0403,   0, 1};
        vecs[4] = '{0, 32'hFFFF_FFFE, 255, 1};
        vecs[5] = '{1, 32'h0000_0014,   5, 3};
        vecs[6] = '{2, 32'h0000_0010,   4, 4};
        vecs[7] = '{2, 32'h0000_07F0, 252, 4};

        // Reset held with a request pending: nothing may come out.
        rstz = 1'b0;
        req  = 1'b1;
        busy = 1'b0;
        addr = 32'h0;
        #2;
        for (int k = 0; k < 3; k++) begin
            check("reset_out", {29'b0, gnt[k], en[k], |data[k]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        req  = 1'b0;
        rstz = 1'b1;

        for (int v = 0; v < 8; v++) begin
            single_read(vecs[v].sel, vecs[v].addr, vecs[v].idx, vecs[v].lat);
        end

        stream(0, 32'h0000_0000, 128, 1'b0, 1, 1);
        stream(2, 32'h0000_0010,   6, 1'b0, 4, 4);
        stream(1, 32'h0000_0100,   6, 1'b0, 3, 3);
        stream(0, 32'h0000_0000, 128, 1'b1, 0, -1);
        stream(0, 32'h0000_03FC,   2, 1'b0, 1, 1);

        // Redirect in READ at WAIT_STATES=0: re-issued the same cycle.
        tick();
        req  = 1'b1;
        addr = 32'h20;
        #1;
        check("rd0_issue", 32'(en[0]), 32'd1);
        tick();
        addr = 32'h80;
        #1;
        check("rd0_no_gnt", 32'(gnt[0]), 32'd0);
        check("rd0_reissue", 32'(en[0]), 32'd1);
        check("rd0_saddr", 32'(saddr[0]), 32'd32);
        tick();
        #1;
        check("rd0_gnt", 32'(gnt[0]), 32'd1);
        check("rd0_data", data[0], mem[32]);
        req = 1'b0;

        // Redirect in HOLD at WAIT_STATES=2: dropped, re-issued from IDLE next cycle.
        tick();
        req  = 1'b1;
        addr = 32'h20;
        #1;
        check("rd2_issue", 32'(en[1]), 32'd1);
        tick();
        tick();
        addr = 32'h80;
        #1;
        check("rd2_drop", {30'b0, gnt[1], en[1]}, 32'd0);
        tick();
        #1;
        check("rd2_reissue", 32'(en[1]), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            #1;
            if (c < 3) begin
                check("rd2_quiet", 32'(gnt[1]), 32'd0);
            end else begin
                check("rd2_gnt", 32'(gnt[1]), 32'd1);
                check("rd2_data", data[1], mem[32]);
            end
        end
        req = 1'b0;

        // Flush in READ, then the same address again must start a fresh read.
        tick();
        req  = 1'b1;
        addr = 32'h40;
        tick();
        req = 1'b0;
        #1;
        check("flush_quiet", {30'b0, gnt[0], en[0]}, 32'd0);
        tick();
        req = 1'b1;
        #1;
        check("flush_idle", {30'b0, gnt[0], en[0]}, 32'd1);
        tick();
        #1;
        check("flush_gnt", 32'(gnt[0]), 32'd1);
        check("flush_data", data[0], mem[16]);
        req = 1'b0;

        // Reset in the final HOLD cycle of WAIT_STATES=3, with the request still held.
        tick();
        req  = 1'b1;
        addr = 32'h10;
        repeat (4) tick();
        rstz = 1'b0;
        #1;
        check("rst_hold_out", {30'b0, gnt[2], en[2]}, 32'd0);
        tick();
        check("rst_held_out", {29'b0, gnt[2], en[2], |data[2]}, 32'd0);
        req  = 1'b0;
        rstz = 1'b1;
        single_read(2, 32'h10, 4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
